msdap_alu: RTL and testbench
============================

# msdap_alu

Filter compute stage of the MSDAP datapath, sitting directly upstream of the parallel-to-serial output stage. On each new input sample it evaluates the shift-add FIR y(n) = ½(…½(½·S1 + S2)… + S16). Each group sum Su is the signed sum of ±x(n−k) over the coefficients in group u. It then presents the 40-bit result on PDATAOUT with a one-cycle LOAD pulse that feeds the P2S LOAD/PDATAIN pins. Coefficient, rj and sample storage live outside the block and are reached through synchronous-read ports.

## Interface
- No parameters.
- SCLK  in  1  system clock (26.88 MHz); all logic on its rising edge
- CLR  in  1  synchronous active-high reset
- START  in  1  one-cycle pulse: new sample x(n) written at WPTR
- WPTR  in  8  data-memory address holding x(n)
- RADDR  out  4  rj memory address (group index u)
- RDATA  in  10  rj count for group u, valid 1 cycle after RADDR
- CADDR  out  9  coefficient memory address
- CDATA  in  9  coefficient: [8] sign (1 = subtract), [7:0] delay k; valid 1 cycle after CADDR
- DADDR  out  8  data memory address = (WPTR − k) mod 256
- DDATA  in  16  signed sample, valid 1 cycle after DADDR
- PDATAOUT  out  40  result y(n), held until the next LOAD
- LOAD  out  1  one-cycle strobe, PDATAOUT valid
- BUSY  out  1  high from the cycle after START is accepted until LOAD

## Operation
- FSM states: IDLE, RJ, LOADRJ, COEF, DRAIN, SHIFT, DONE.
- IDLE: START=1 captures WPTR, clears ACC and the coefficient pointer cp and group index u, and increments NSAMP (9-bit, saturates at 256). Next state is RJ.
- RJ: drive RADDR=u. Next state is LOADRJ.
- LOADRJ: latch rem=RDATA. Next state is COEF if rem≠0, else DRAIN.
- COEF: issue CADDR=cp, then cp++ (wraps mod 512) and rem−−, one coefficient per cycle. Leave for DRAIN when rem reaches 0.
- DRAIN: 2 cycles to flush the CDATA→DADDR→DDATA pipeline.
- SHIFT: ACC ← ACC >>> 1 (arithmetic). u++. Next state is DONE if u was 15, else RJ.
- DONE: PDATAOUT ← ACC and LOAD=1 for this one cycle. Return to IDLE.
- Term formation: x is DDATA sign-extended to 24 bits and concatenated with 16'b0, giving a 40-bit term. ACC ± term uses 40-bit two's-complement arithmetic, wrapping on overflow.
- History validity: a term is forced to 0 if k ≥ NSAMP, i.e. the sample precedes the first one after CLR.
- rj=0 groups: the group still costs RJ+LOADRJ+DRAIN+SHIFT (5 cycles) and adds nothing.
- START while BUSY is ignored; no queuing.
- CLR at any time, including mid-computation: state=IDLE, and ACC, NSAMP, cp, u, PDATAOUT are all cleared. All outputs become 0 on the next edge.

## Timing
- Reset values: PDATAOUT=0, LOAD=0, BUSY=0, RADDR=0, CADDR=0, DADDR=0.
- Memory read latency is fixed at one cycle on all three ports.
- Group u costs rj_u + 5 cycles.
- LOAD is high exactly 80 + Σrj cycles after the edge that samples START, for Σrj ≤ 512.
- PDATAOUT changes only on the LOAD cycle. It is stable for P2S across its full 40-bit shift.
- BUSY drops in the same cycle LOAD rises, so the next START may arrive in the cycle after LOAD.

## Configuration
- MSDAP_ALU_OVF_EN defined: an extra output OVF (1 bit) is added.
  - OVF is a sticky flag that sets on any signed overflow of an ACC add/sub.
  - It clears on accepted START and on CLR, and is valid alongside LOAD.
- MSDAP_ALU_OVF_EN undefined: the OVF port and its logic are absent. Arithmetic wraps silently; behaviour is otherwise identical.

## Test plan
- CLR held 2 cycles, then released -> all outputs 0, BUSY=0, no LOAD without START.
- rj0=1, other rj=0, coef0=+0, first START with x=0x0100 -> LOAD 81 cycles later, PDATAOUT=40'h0000000100.
- rj0=1, coef0=9'h100 (−, k=0), x=0x0001 -> PDATAOUT=40'hFFFFFFFFFF.
- rj15=1 only, coef0=+0, x=0x4000 -> PDATAOUT=40'h0020000000. Repeat with k=3 on the first sample -> PDATAOUT=0 (history gated).
- Second START 10 cycles after the first -> ignored, single LOAD. CLR asserted mid-COEF -> BUSY=0 next cycle, PDATAOUT=0, no LOAD.
- Full load: Σrj=512 with random ±k, checked against a golden model over 300 samples spanning NSAMP saturation, including WPTR wrap 255→0.

Source files
------------

// File: rtl/msdap_alu.sv
// MSDAP filter compute stage: shift-add FIR over 16 coefficient groups, result strobed to P2S.
// Define MSDAP_ALU_OVF_EN to add the sticky signed-overflow output OVF.
module msdap_alu (
  input  logic        SCLK,
  input  logic        CLR,
  input  logic        START,
  input  logic [7:0]  WPTR,
  output logic [3:0]  RADDR,
  input  logic [9:0]  RDATA,
  output logic [8:0]  CADDR,
  input  logic [8:0]  CDATA,
  output logic [7:0]  DADDR,
  input  logic [15:0] DDATA,
  output logic [39:0] PDATAOUT,
  output logic        LOAD,
  output logic        BUSY
`ifdef MSDAP_ALU_OVF_EN
  ,
  output logic        OVF
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_RJ, S_LOADRJ, S_COEF, S_DRAIN, S_SHIFT, S_DONE
  } state_t;

  state_t      r_state;
  logic [7:0]  r_wptr;
  logic [39:0] r_acc;
  logic [8:0]  r_cp;
  logic [3:0]  r_u;
  logic [8:0]  r_nsamp;
  logic [9:0]  r_rem;
  logic        r_drain;
  logic        r_v1, r_v2, r_v3;
  logic        r_s2, r_s3;
  logic [7:0]  r_daddr;
  logic [39:0] r_pdata;
  logic        r_load;
  logic        r_busy;

  logic [39:0] w_x40, w_term, w_sum, w_shift;

  // Pipeline: CADDR (cycle t) -> CDATA/DADDR calc (t+1) -> DADDR out (t+2) -> DDATA accumulate (t+3).
  // The last term therefore lands in SHIFT, which adds and halves in one step.
  always_comb begin
    w_x40   = {{8{DDATA[15]}}, DDATA, 16'h0000};
    w_term  = '0;
    if (r_v3) w_term = r_s3 ? -w_x40 : w_x40;
    w_sum   = r_acc + w_term;
    w_shift = {w_sum[39], w_sum[39:1]};
  end

  always_ff @(posedge SCLK) begin
    if (CLR) begin
      r_state <= S_IDLE;
      r_wptr  <= '0;
      r_acc   <= '0;
      r_cp    <= '0;
      r_u     <= '0;
      r_nsamp <= '0;
      r_rem   <= '0;
      r_drain <= 1'b0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_daddr <= '0;
      r_pdata <= '0;
      r_load  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_load <= 1'b0;
      r_acc  <= w_sum;
      r_v1   <= (r_state == S_COEF);
      r_v3   <= r_v2;
      r_s3   <= r_s2;
      if (r_v1) begin
        r_daddr <= r_wptr - CDATA[7:0];
        r_s2    <= CDATA[8];
        // Delays reaching before the first sample since CLR contribute nothing.
        r_v2    <= ({1'b0, CDATA[7:0]} < r_nsamp);
      end else begin
        r_v2 <= 1'b0;
      end

      unique case (r_state)
        S_IDLE: begin
          if (START) begin
            r_wptr  <= WPTR;
            r_acc   <= '0;
            r_cp    <= '0;
            r_u     <= '0;
            r_nsamp <= (r_nsamp == 9'd256) ? r_nsamp : r_nsamp + 9'd1;
            r_busy  <= 1'b1;
            r_state <= S_RJ;
          end
        end
        S_RJ: r_state <= S_LOADRJ;
        S_LOADRJ: begin
          r_rem   <= RDATA;
          r_drain <= 1'b0;
          r_state <= (RDATA != '0) ? S_COEF : S_DRAIN;
        end
        S_COEF: begin
          r_cp  <= r_cp + 9'd1;
          r_rem <= r_rem - 10'd1;
          if (r_rem == 10'd1) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          r_drain <= 1'b1;
          if (r_drain) r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_acc <= w_shift;
          r_u   <= r_u + 4'd1;
          if (r_u == 4'd15) begin
            r_pdata <= w_shift;
            r_load  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_state <= S_RJ;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MSDAP_ALU_OVF_EN
  logic r_ovf;
  logic w_ovf;

  always_comb begin
    w_ovf = r_v3 && (r_acc[39] == w_term[39]) && (w_sum[39] != r_acc[39]);
  end

  always_ff @(posedge SCLK) begin
    if (CLR) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_IDLE && START) begin
      r_ovf <= 1'b0;
    end else if (w_ovf) begin
      r_ovf <= 1'b1;
    end
  end

  assign OVF = r_ovf;
`endif

  assign RADDR    = r_u;
  assign CADDR    = r_cp;
  assign DADDR    = r_daddr;
  assign PDATAOUT = r_pdata;
  assign LOAD     = r_load;
  assign BUSY     = r_busy;

endmodule

// File: tb/tb_msdap_alu.sv
// Directed-vector and golden-model bench for msdap_alu with synchronous-read memory models.
module tb_msdap_alu;

  logic        clk = 1'b0;
  logic        clr, start;
  logic [7:0]  wptr;
  logic [3:0]  raddr;
  logic [9:0]  rdata;
  logic [8:0]  caddr;
  logic [8:0]  cdata;
  logic [7:0]  daddr;
  logic [15:0] ddata;
  logic [39:0] pdataout;
  logic        load, busy;
`ifdef MSDAP_ALU_OVF_EN
  logic        ovf;
`endif

  always #5 clk = ~clk;

  msdap_alu dut (
    .SCLK(clk), .CLR(clr), .START(start), .WPTR(wptr),
    .RADDR(raddr), .RDATA(rdata), .CADDR(caddr), .CDATA(cdata),
    .DADDR(daddr), .DDATA(ddata), .PDATAOUT(pdataout), .LOAD(load), .BUSY(busy)
`ifdef MSDAP_ALU_OVF_EN
    , .OVF(ovf)
`endif
  );

  logic [9:0]  rj_mem   [16];
  logic [8:0]  coef_mem [512];
  logic [15:0] data_mem [256];

  always @(posedge clk) begin
    rdata <= rj_mem[raddr];
    cdata <= coef_mem[caddr];
    ddata <= data_mem[daddr];
  end

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One idle cycle first so START never lands in the DONE cycle.
  task automatic run_sample(input logic [7:0] wp, input logic [15:0] x,
                            output int lat, output logic [39:0] res);
    tick();
    data_mem[wp] = x;
    wptr  = wp;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat   = 0;
    while (lat < 3000) begin
      tick();
      lat++;
      if (load) break;
    end
    res = pdataout;
  endtask

  function automatic logic [39:0] model(input logic [7:0] wp, input int unsigned ns);
    logic signed [39:0] acc;
    logic [39:0]        t;
    logic [8:0]         c;
    logic [15:0]        x;
    int unsigned        cp;
    acc = '0;
    cp  = 0;
    for (int u = 0; u < 16; u++) begin
      for (int j = 0; j < int'(rj_mem[u]); j++) begin
        c  = coef_mem[cp % 512];
        cp = cp + 1;
        if (int'(c[7:0]) < ns) begin
          x = data_mem[8'(wp - c[7:0])];
          t = {{8{x[15]}}, x, 16'h0000};
          acc = c[8] ? acc - t : acc + t;
        end
      end
      acc = acc >>> 1;
    end
    return acc;
  endfunction

  typedef struct {
    logic        do_clr;
    logic [3:0]  grp;
    logic [8:0]  coef;
    logic [7:0]  wp;
    logic [15:0] x;
    logic [39:0] exp;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int          lat;
    int          nload;
    int          sumrj;
    logic [39:0] res;

    vecs[0] = '{1'b1, 4'd0,  9'h000, 8'h10, 16'h0100, 40'h0000000100};
    vecs[1] = '{1'b1, 4'd0,  9'h100, 8'h10, 16'h0001, 40'hFFFFFFFFFF};
    vecs[2] = '{1'b1, 4'd15, 9'h000, 8'h10, 16'h4000, 40'h0020000000};
    vecs[3] = '{1'b1, 4'd15, 9'h003, 8'h20, 16'h4000, 40'h0000000000};
    vecs[4] = '{1'b0, 4'd15, 9'h001, 8'h21, 16'h1234, 40'h0020000000};
    vecs[5] = '{1'b0, 4'd15, 9'h102, 8'h22, 16'h5555, 40'hFFE0000000};
    vecs[6] = '{1'b0, 4'd7,  9'h000, 8'h23, 16'h8000, 40'hFFFFC00000};
    vecs[7] = '{1'b0, 4'd0,  9'h000, 8'h24, 16'h7FFF, 40'h0000007FFF};
    vecs[8] = '{1'b0, 4'd15, 9'h000, 8'hFF, 16'h0200, 40'h0001000000};
    vecs[9] = '{1'b0, 4'd15, 9'h001, 8'h00, 16'h0000, 40'h0001000000};

    for (int i = 0; i < 16; i++)  rj_mem[i]   = '0;
    for (int i = 0; i < 512; i++) coef_mem[i] = '0;
    for (int i = 0; i < 256; i++) data_mem[i] = '0;

    clr = 1'b1; start = 1'b0; wptr = '0;
    tick(); tick();
    clr = 1'b0;
    check("rst_pdataout", pdataout, '0);
    check("rst_load", {39'd0, load}, '0);
    check("rst_busy", {39'd0, busy}, '0);
    check("rst_raddr", {36'd0, raddr}, '0);
    check("rst_caddr", {31'd0, caddr}, '0);
    check("rst_daddr", {32'd0, daddr}, '0);
    nload = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (load || busy) nload++;
    end
    check("idle_no_activity", 40'(nload), 40'd0);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_clr) begin
        clr = 1'b1; tick(); clr = 1'b0;
      end
      for (int g = 0; g < 16; g++) rj_mem[g] = '0;
      rj_mem[vecs[i].grp] = 10'd1;
      coef_mem[0] = vecs[i].coef;
      run_sample(vecs[i].wp, vecs[i].x, lat, res);
      check($sformatf("vec%0d_latency", i), 40'(lat), 40'd81);
      check($sformatf("vec%0d_pdataout", i), res, vecs[i].exp);
    end

    // Second START while busy must be dropped.
    for (int g = 0; g < 16; g++) rj_mem[g] = '0;
    rj_mem[0] = 10'd1;
    coef_mem[0] = 9'h000;
    tick();
    data_mem[8'h40] = 16'h0100;
    wptr = 8'h40;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", {39'd0, busy}, 40'd1);
    nload = 0; lat = 0;
    for (int c = 1; c <= 300; c++) begin
      tick();
      if (load) begin
        nload++;
        lat = c;
        check("busy_low_at_load", {39'd0, busy}, 40'd0);
        check("dbl_pdataout", pdataout, 40'h0000000100);
      end
      start = (c == 10);
    end
    start = 1'b0;
    check("dbl_start_loads", 40'(nload), 40'd1);
    check("dbl_start_latency", 40'(lat), 40'd81);

    // CLR mid-COEF aborts the computation.
    rj_mem[0] = 10'd100;
    tick();
    wptr = 8'h41;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    check("abort_busy", {39'd0, busy}, 40'd0);
    check("abort_pdataout", pdataout, '0);
    check("abort_caddr", {31'd0, caddr}, '0);
    check("abort_raddr", {36'd0, raddr}, '0);
    check("abort_daddr", {32'd0, daddr}, '0);
    nload = 0;
    for (int c = 0; c < 700; c++) begin
      tick();
      if (load) nload++;
    end
    check("abort_no_load", 40'(nload), 40'd0);

    // Golden-model run through NSAMP saturation and WPTR wrap, ending with full 512-tap loads.
    for (int i = 0; i < 512; i++) coef_mem[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))};
    for (int g = 0; g < 16; g++) rj_mem[g] = 10'd1;
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 0; i < 300; i++) begin
      logic [7:0]  wp;
      logic [15:0] x;
      if (i == 294) for (int g = 0; g < 16; g++) rj_mem[g] = 10'd32;
      sumrj = (i >= 294) ? 512 : 16;
      wp = 8'(200 + i);
      x  = 16'($urandom);
      run_sample(wp, x, lat, res);
      check($sformatf("gold%0d_latency", i), 40'(lat), 40'(80 + sumrj));
      check($sformatf("gold%0d_pdataout", i), res, model(wp, (i + 1 > 256) ? 256 : i + 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
